reg_ac_stack: RTL and testbench
===============================

// Module: reg_ac_stack
// PURPOSE
//  Parametrised successor to the accumulator register: a WIDTH-bit accumulator fed by the
//  data bus or the ALU, plus a DEPTH-entry LIFO save stack for context push/pop/exchange.
//  Sits in the datapath between the bus mux and ALU input A. Drives zero/negative flags to
//  the control unit and raises sticky error flags on conflicts and stack misuse.
// PARAMETERS
//  WIDTH   16  accumulator and stack entry width in bits
//  DEPTH   4   save-stack entries (>=2); CW = $clog2(DEPTH+1) is the count width
// PORTS
//  clk           in   1      single clock; all state updates on posedge
//  reset         in   1      synchronous, active-high; dominates all other inputs
//  write_en      in   1      load acc from datain
//  datain        in   WIDTH  bus data
//  alu_write_en  in   1      load acc from alu_out
//  alu_out       in   WIDTH  ALU result
//  push          in   1      save current acc (pre-update value) onto stack
//  pop           in   1      restore top of stack into acc
//  err_clear     in   1      clear all sticky error flags
//  dataout       out  WIDTH  accumulator value (registered)
//  zero          out  1      dataout == 0 (combinational from dataout)
//  neg           out  1      dataout[WIDTH-1]
//  stk_count     out  CW     entries held, 0..DEPTH
//  stk_full      out  1      stk_count == DEPTH
//  stk_empty     out  1      stk_count == 0
//  err_conflict  out  1      sticky: illegal source combination seen
//  err_ovf       out  1      sticky: push while full
//  err_unf       out  1      sticky: pop while empty
// BEHAVIOUR
//  - Reset: dataout=0, stk_count=0, all err_*=0; stack contents don't-care. Reset wins even
//    with enables/push/pop asserted; a mid-operation reset discards the whole stack.
//  - Acc source per cycle (1-cycle latency, new value visible after the edge):
//    write_en only -> datain; alu_write_en only -> alu_out; pop only (non-empty) -> top.
//    Two or more of {write_en, alu_write_en, pop} with push=0 -> acc and stack hold,
//    err_conflict<=1.
//  - push alone: stack[count]<=dataout, count+1. push with exactly one of write_en or
//    alu_write_en: push old dataout AND load acc in the same cycle (save-and-load).
//    push with write_en and alu_write_en: conflict rule applies, nothing changes.
//  - push & pop (no writes) = exchange: acc<=top, top<=old acc, count unchanged; empty ->
//    err_unf<=1, hold. push & pop with any write -> conflict, hold.
//  - push when full: stack/count unchanged, err_ovf<=1; accompanying acc load still occurs.
//  - pop when empty: acc/count hold, err_unf<=1 (no conflict flag if pop was sole request).
//  - err_clear clears flags at the edge; an error event in the same cycle wins (flag stays 1).
//  - No enables: everything holds. Stack is pure LIFO, no wrap-around.
// STRUCTURE
//  - Shared package acc_pkg: default WIDTH/DEPTH localparams; enum of acc-source select
//    {SRC_HOLD, SRC_BUS, SRC_ALU, SRC_STK, SRC_ZERO}; stack-op enum {OP_NONE, OP_PUSH,
//    OP_POP, OP_XCHG}.
//  - One sub-module acc_lifo (storage array, count, full/empty, push/pop/xchg ports with
//    error outputs). Top level holds decode, acc register, flags, sticky errors.
// TESTING
//  1. reset=1 with write_en=1, datain=16'h1234 -> dataout=0, stk_count=0, all err=0.
//  2. write_en, datain=16'h8000 -> dataout=16'h8000, neg=1, zero=0; then alu_write_en,
//     alu_out=0 -> dataout=0, zero=1.
//  3. acc=16'h00AA; push+write_en datain=16'h0055 -> dataout=16'h0055, stk_count=1; pop ->
//     dataout=16'h00AA, stk_count=0; second pop -> dataout held, err_unf=1.
//  4. Fill DEPTH=4 with pushes of 1,2,3,4 -> stk_full=1; 5th push -> err_ovf=1, count 4;
//     four pops return 4,3,2,1 in order.
//  5. write_en & alu_write_en both 1 -> dataout held, err_conflict=1; err_clear -> 0;
//     err_clear together with pop+write_en -> err_conflict stays 1.
//  6. acc=16'h0011, top=16'h0022; push&pop -> dataout=16'h0022, top=16'h0011, count same;
//     then reset mid-stack -> stk_empty=1, dataout=0.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types and defaults for the accumulator with LIFO save stack.
package acc_pkg;

    localparam int ACC_WIDTH = 16;
    localparam int ACC_DEPTH = 4;

    // Where the accumulator takes its next value from in a given cycle
    typedef enum logic [2:0] {
        SRC_HOLD,
        SRC_BUS,
        SRC_ALU,
        SRC_STK,
        SRC_ZERO
    } acc_src_t;

    // Operation requested of the save stack in a given cycle
    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_XCHG
    } stk_op_t;

endpackage

// File: rtl/reg_ac_stack_if.sv
// Datapath-side bundle of the accumulator: load/stack controls in, value/flags out.
interface reg_ac_stack_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic             write_en;
    logic [WIDTH-1:0] datain;
    logic             alu_write_en;
    logic [WIDTH-1:0] alu_out;
    logic             push;
    logic             pop;
    logic             err_clear;
    logic [WIDTH-1:0] dataout;
    logic             zero;
    logic             neg;
    logic [CW-1:0]    stk_count;
    logic             stk_full;
    logic             stk_empty;
    logic             err_conflict;
    logic             err_ovf;
    logic             err_unf;

    // Control side: issues loads and stack requests, observes the accumulator
    modport master (
        output write_en, datain, alu_write_en, alu_out, push, pop, err_clear,
        input  dataout, zero, neg, stk_count, stk_full, stk_empty,
               err_conflict, err_ovf, err_unf
    );

    // Accumulator side
    modport slave (
        input  write_en, datain, alu_write_en, alu_out, push, pop, err_clear,
        output dataout, zero, neg, stk_count, stk_full, stk_empty,
               err_conflict, err_ovf, err_unf
    );
endinterface

// File: rtl/acc_lifo.sv
// DEPTH-entry LIFO holding saved accumulator contexts; no wrap-around.
// Misuse (push while full, pop/exchange while empty) leaves state untouched
// and is reported on single-cycle ovf_o/unf_o strobes.
module acc_lifo
    import acc_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH,
    parameter int DEPTH = ACC_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  stk_op_t          op_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] top_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             ovf_o,
    output logic             unf_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [CW-1:0]    top_idx;
    logic             do_push;
    logic             do_pop;
    logic             do_xchg;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Top entry sits one below the count; only meaningful when non-empty
    assign top_idx = count_q - CW'(1);
    assign top_o   = mem_q[top_idx[AW-1:0]];

    assign do_push = (op_i == OP_PUSH) && !full_o;
    assign do_pop  = (op_i == OP_POP)  && !empty_o;
    assign do_xchg = (op_i == OP_XCHG) && !empty_o;

    assign ovf_o = (op_i == OP_PUSH) && full_o;
    assign unf_o = ((op_i == OP_POP) || (op_i == OP_XCHG)) && empty_o;

    // Next occupancy: exchange keeps the count
    always_comb begin
        count_d = count_q;
        if (do_push) begin
            count_d = count_q + CW'(1);
        end else if (do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Occupancy register; reset empties the stack, contents become don't-care
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage: push writes the slot above the top, exchange overwrites the top
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (do_push) begin
                mem_q[count_q[AW-1:0]] <= din_i;
            end else if (do_xchg) begin
                mem_q[top_idx[AW-1:0]] <= din_i;
            end
        end
    end

endmodule

// File: rtl/reg_ac_stack.sv
// Accumulator register fed from the bus or ALU, with a LIFO save stack for
// context push/pop/exchange, status flags and sticky misuse errors.
module reg_ac_stack
    import acc_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH,
    parameter int DEPTH = ACC_DEPTH
) (
    input  logic           clk,
    input  logic           reset,
    reg_ac_stack_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    acc_src_t         src_sel;
    stk_op_t          stk_op;
    logic             conflict;
    logic [WIDTH-1:0] stk_top;
    logic [CW-1:0]    stk_count;
    logic             stk_full;
    logic             stk_empty;
    logic             stk_ovf;
    logic             stk_unf;
    logic             err_conflict_q;
    logic             err_ovf_q;
    logic             err_unf_q;

    // Decode the request mix into an accumulator source and a stack operation.
    // Any illegal mix requests nothing from either and only raises conflict.
    always_comb begin
        src_sel  = SRC_HOLD;
        stk_op   = OP_NONE;
        conflict = 1'b0;
        if (bus.push) begin
            if (bus.pop) begin
                if (bus.write_en || bus.alu_write_en) begin
                    conflict = 1'b1;
                end else begin
                    stk_op  = OP_XCHG;
                    src_sel = SRC_STK;
                end
            end else if (bus.write_en && bus.alu_write_en) begin
                conflict = 1'b1;
            end else begin
                // Save-and-load: the stack captures the pre-edge accumulator
                stk_op = OP_PUSH;
                if (bus.write_en) begin
                    src_sel = SRC_BUS;
                end else if (bus.alu_write_en) begin
                    src_sel = SRC_ALU;
                end
            end
        end else begin
            case ({bus.write_en, bus.alu_write_en, bus.pop})
                3'b000:  src_sel = SRC_HOLD;
                3'b100:  src_sel = SRC_BUS;
                3'b010:  src_sel = SRC_ALU;
                3'b001: begin
                    stk_op  = OP_POP;
                    src_sel = SRC_STK;
                end
                default: conflict = 1'b1;
            endcase
        end
    end

    // Next accumulator value; a stack read from an empty stack holds instead
    always_comb begin
        acc_d = acc_q;
        case (src_sel)
            SRC_BUS:  acc_d = bus.datain;
            SRC_ALU:  acc_d = bus.alu_out;
            SRC_STK:  acc_d = stk_empty ? acc_q : stk_top;
            SRC_ZERO: acc_d = '0;
            default:  acc_d = acc_q;
        endcase
    end

    acc_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_lifo (
        .clk     (clk),
        .reset   (reset),
        .op_i    (stk_op),
        .din_i   (acc_q),
        .top_o   (stk_top),
        .count_o (stk_count),
        .full_o  (stk_full),
        .empty_o (stk_empty),
        .ovf_o   (stk_ovf),
        .unf_o   (stk_unf)
    );

    // Accumulator and sticky errors; a new error event outranks err_clear
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q          <= '0;
            err_conflict_q <= 1'b0;
            err_ovf_q      <= 1'b0;
            err_unf_q      <= 1'b0;
        end else begin
            acc_q          <= acc_d;
            err_conflict_q <= (err_conflict_q & ~bus.err_clear) | conflict;
            err_ovf_q      <= (err_ovf_q      & ~bus.err_clear) | stk_ovf;
            err_unf_q      <= (err_unf_q      & ~bus.err_clear) | stk_unf;
        end
    end

    assign bus.dataout      = acc_q;
    assign bus.zero         = (acc_q == '0);
    assign bus.neg          = acc_q[WIDTH-1];
    assign bus.stk_count    = stk_count;
    assign bus.stk_full     = stk_full;
    assign bus.stk_empty    = stk_empty;
    assign bus.err_conflict = err_conflict_q;
    assign bus.err_ovf      = err_ovf_q;
    assign bus.err_unf      = err_unf_q;

endmodule

// File: tb/tb_reg_ac_stack.sv
// Directed bench for reg_ac_stack: linear sequence of steps with hand-computed expectations.
module tb_reg_ac_stack;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    reg_ac_stack_if #(.WIDTH(16), .DEPTH(4)) bus ();

    reg_ac_stack #(
        .WIDTH (16),
        .DEPTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Let one edge pass with the current inputs, then settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.write_en     = 1'b0;
        bus.alu_write_en = 1'b0;
        bus.push         = 1'b0;
        bus.pop          = 1'b0;
        bus.err_clear    = 1'b0;
    endtask

    task automatic check_errs(input string tag, input logic c, input logic o, input logic u);
        check({tag, ".err_conflict"}, {31'd0, bus.err_conflict}, {31'd0, c});
        check({tag, ".err_ovf"},      {31'd0, bus.err_ovf},      {31'd0, o});
        check({tag, ".err_unf"},      {31'd0, bus.err_unf},      {31'd0, u});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle();
        bus.datain  = 16'h0;
        bus.alu_out = 16'h0;

        // 1: reset dominates an asserted write
        reset = 1'b1;
        bus.write_en = 1'b1;
        bus.datain   = 16'h1234;
        step();
        step();
        $display("txn reset with write_en: dataout=%h count=%0d", bus.dataout, bus.stk_count);
        check("rst.dataout", 32'(bus.dataout), 32'h0);
        check("rst.count", 32'(bus.stk_count), 32'd0);
        check("rst.empty", 32'(bus.stk_empty), 32'd1);
        check_errs("rst", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        idle();

        // 2: bus load with sign bit, then ALU load of zero
        bus.write_en = 1'b1;
        bus.datain   = 16'h8000;
        step();
        $display("txn bus load 8000: dataout=%h neg=%b zero=%b", bus.dataout, bus.neg, bus.zero);
        check("bus.dataout", 32'(bus.dataout), 32'h8000);
        check("bus.neg", 32'(bus.neg), 32'd1);
        check("bus.zero", 32'(bus.zero), 32'd0);
        idle();
        bus.alu_write_en = 1'b1;
        bus.alu_out      = 16'h0000;
        step();
        $display("txn alu load 0000: dataout=%h zero=%b", bus.dataout, bus.zero);
        check("alu.dataout", 32'(bus.dataout), 32'h0);
        check("alu.zero", 32'(bus.zero), 32'd1);
        check("alu.neg", 32'(bus.neg), 32'd0);
        idle();

        // 3: save-and-load, restore, then underflow
        bus.write_en = 1'b1;
        bus.datain   = 16'h00AA;
        step();
        bus.push   = 1'b1;
        bus.datain = 16'h0055;
        step();
        $display("txn push+write 0055: dataout=%h count=%0d", bus.dataout, bus.stk_count);
        check("sal.dataout", 32'(bus.dataout), 32'h0055);
        check("sal.count", 32'(bus.stk_count), 32'd1);
        idle();
        bus.pop = 1'b1;
        step();
        $display("txn pop: dataout=%h count=%0d", bus.dataout, bus.stk_count);
        check("pop1.dataout", 32'(bus.dataout), 32'h00AA);
        check("pop1.count", 32'(bus.stk_count), 32'd0);
        check("pop1.empty", 32'(bus.stk_empty), 32'd1);
        step();
        $display("txn pop on empty: dataout=%h err_unf=%b", bus.dataout, bus.err_unf);
        check("unf.dataout", 32'(bus.dataout), 32'h00AA);
        check("unf.count", 32'(bus.stk_count), 32'd0);
        check_errs("unf", 1'b0, 1'b0, 1'b1);
        idle();
        bus.err_clear = 1'b1;
        step();
        check_errs("clr1", 1'b0, 1'b0, 1'b0);
        idle();

        // 4: fill to DEPTH, overflow with accompanying load, drain in LIFO order
        for (int i = 1; i <= 4; i++) begin
            bus.write_en = 1'b1;
            bus.datain   = 16'(i);
            step();
            idle();
            bus.push = 1'b1;
            step();
            idle();
            $display("txn push %0d: count=%0d", i, bus.stk_count);
            check("fill.count", 32'(bus.stk_count), 32'(i));
        end
        check("fill.full", 32'(bus.stk_full), 32'd1);
        check("fill.empty", 32'(bus.stk_empty), 32'd0);
        bus.push     = 1'b1;
        bus.write_en = 1'b1;
        bus.datain   = 16'h0005;
        step();
        $display("txn push when full: count=%0d err_ovf=%b dataout=%h", bus.stk_count, bus.err_ovf, bus.dataout);
        check("ovf.count", 32'(bus.stk_count), 32'd4);
        check("ovf.dataout", 32'(bus.dataout), 32'h0005);
        check_errs("ovf", 1'b0, 1'b1, 1'b0);
        idle();
        for (int i = 4; i >= 1; i--) begin
            bus.pop = 1'b1;
            step();
            idle();
            $display("txn drain pop: dataout=%h count=%0d", bus.dataout, bus.stk_count);
            check("drain.dataout", 32'(bus.dataout), 32'(i));
            check("drain.count", 32'(bus.stk_count), 32'(i - 1));
        end
        check("drain.empty", 32'(bus.stk_empty), 32'd1);
        bus.err_clear = 1'b1;
        step();
        idle();
        check_errs("clr2", 1'b0, 1'b0, 1'b0);

        // 5: source conflicts and clear-vs-event priority
        bus.write_en = 1'b1;
        bus.datain   = 16'h0077;
        step();
        bus.alu_write_en = 1'b1;
        bus.datain       = 16'h1111;
        bus.alu_out      = 16'h2222;
        step();
        $display("txn write+alu conflict: dataout=%h err_conflict=%b", bus.dataout, bus.err_conflict);
        check("cf.dataout", 32'(bus.dataout), 32'h0077);
        check_errs("cf", 1'b1, 1'b0, 1'b0);
        idle();
        bus.err_clear = 1'b1;
        step();
        check_errs("cfclr", 1'b0, 1'b0, 1'b0);
        bus.pop      = 1'b1;
        bus.write_en = 1'b1;
        step();
        $display("txn clear with pop+write: err_conflict=%b dataout=%h", bus.err_conflict, bus.dataout);
        check("cfpri.dataout", 32'(bus.dataout), 32'h0077);
        check("cfpri.count", 32'(bus.stk_count), 32'd0);
        check_errs("cfpri", 1'b1, 1'b0, 1'b0);
        idle();
        bus.push         = 1'b1;
        bus.write_en     = 1'b1;
        bus.alu_write_en = 1'b1;
        step();
        $display("txn push+write+alu conflict: count=%0d dataout=%h", bus.stk_count, bus.dataout);
        check("cfpush.count", 32'(bus.stk_count), 32'd0);
        check("cfpush.dataout", 32'(bus.dataout), 32'h0077);
        idle();
        bus.err_clear = 1'b1;
        step();
        idle();

        // 6: exchange on empty, exchange proper, then reset discards the stack
        bus.push = 1'b1;
        bus.pop  = 1'b1;
        step();
        $display("txn xchg on empty: dataout=%h err_unf=%b", bus.dataout, bus.err_unf);
        check("xe.dataout", 32'(bus.dataout), 32'h0077);
        check_errs("xe", 1'b0, 1'b0, 1'b1);
        idle();
        bus.err_clear = 1'b1;
        step();
        idle();
        bus.write_en = 1'b1;
        bus.datain   = 16'h0022;
        step();
        idle();
        bus.push = 1'b1;
        step();
        idle();
        bus.write_en = 1'b1;
        bus.datain   = 16'h0011;
        step();
        idle();
        bus.push = 1'b1;
        bus.pop  = 1'b1;
        step();
        idle();
        $display("txn xchg: dataout=%h count=%0d", bus.dataout, bus.stk_count);
        check("xchg.dataout", 32'(bus.dataout), 32'h0022);
        check("xchg.count", 32'(bus.stk_count), 32'd1);
        check_errs("xchg", 1'b0, 1'b0, 1'b0);
        bus.pop = 1'b1;
        step();
        idle();
        $display("txn pop after xchg: dataout=%h count=%0d", bus.dataout, bus.stk_count);
        check("xtop.dataout", 32'(bus.dataout), 32'h0011);
        check("xtop.count", 32'(bus.stk_count), 32'd0);
        bus.push = 1'b1;
        step();
        step();
        idle();
        check("pre_rst.count", 32'(bus.stk_count), 32'd2);
        reset    = 1'b1;
        bus.push = 1'b1;
        step();
        reset = 1'b0;
        idle();
        $display("txn mid-stack reset: dataout=%h count=%0d empty=%b", bus.dataout, bus.stk_count, bus.stk_empty);
        check("mrst.dataout", 32'(bus.dataout), 32'h0);
        check("mrst.empty", 32'(bus.stk_empty), 32'd1);
        check("mrst.count", 32'(bus.stk_count), 32'd0);
        bus.pop = 1'b1;
        step();
        idle();
        $display("txn pop after reset: dataout=%h err_unf=%b", bus.dataout, bus.err_unf);
        check("mrst.pop_dataout", 32'(bus.dataout), 32'h0);
        check_errs("mrst.pop", 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
